// File: rtl/fft_peak_pkg.sv
// Shared definitions for the FFT peak-bin tracker.
//   state_e  : frame FSM encoding
//   mag_w    : |X|^2 width for a signed DATA_W input (2*DATA_W+1)
//   index_w  : bin index width for an NFFT-point frame
package fft_peak_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  function automatic int mag_w(input int data_w);
    return 2 * data_w + 1;
  endfunction

  function automatic int index_w(input int nfft);
    return $clog2(nfft);
  endfunction

endpackage

// File: rtl/fft_peak_bin_tracker_if.sv
// FFT bin stream, one complex bin per beat, no backpressure.
//   bin_valid : beat valid
//   bin_sop   : first bin of frame (qualified by bin_valid)
//   bin_eop   : last bin of frame (qualified by bin_valid)
//   bin_re/im : signed real / imaginary parts
// master = FFT core side, slave = tracker side.
interface fft_peak_bin_tracker_if #(
  parameter int DATA_W = 12
);
  logic                     bin_valid;
  logic                     bin_sop;
  logic                     bin_eop;
  logic signed [DATA_W-1:0] bin_re;
  logic signed [DATA_W-1:0] bin_im;

  modport master (output bin_valid, bin_sop, bin_eop, bin_re, bin_im);
  modport slave  (input  bin_valid, bin_sop, bin_eop, bin_re, bin_im);
endinterface

// File: rtl/fft_mag_sq.sv
// Two-stage |X|^2 pipeline with aligned sideband.
//   stage 1 registers re^2 and im^2, stage 2 registers their sum.
//   in_*  : beat valid, frame sop/eop, bin index, opaque tag
//   out_* : same sideband two cycles later, with out_mag = re^2 + im^2
// Data stages load only on a valid beat; the valid shift register always runs.
module fft_mag_sq import fft_peak_pkg::*; #(
  parameter int DATA_W  = 12,
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 1,
  parameter int MAG_W   = mag_w(DATA_W)
) (
  input  logic                     clk_in,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic                     in_sop,
  input  logic                     in_eop,
  input  logic [INDEX_W-1:0]       in_idx,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic                     out_valid,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [INDEX_W-1:0]       out_idx,
  output logic [TAG_W-1:0]         out_tag,
  output logic [MAG_W-1:0]         out_mag
);
  localparam int SQ_W = 2 * DATA_W;

  logic [1:0]              vld_pipe_q;
  logic signed [SQ_W-1:0]  re_x, im_x;
  logic [SQ_W-1:0]         re_sq_d, im_sq_d, re_sq_q, im_sq_q;
  logic [MAG_W-1:0]        mag_d, mag_q;
  logic                    s1_sop_q, s1_eop_q, s2_sop_q, s2_eop_q;
  logic [INDEX_W-1:0]      s1_idx_q, s2_idx_q;
  logic [TAG_W-1:0]        s1_tag_q, s2_tag_q;

  // Squares are never negative; (-2^(DATA_W-1))^2 still fits SQ_W-1 bits.
  always_comb begin
    re_x    = {{DATA_W{in_re[DATA_W-1]}}, in_re};
    im_x    = {{DATA_W{in_im[DATA_W-1]}}, in_im};
    re_sq_d = re_x * re_x;
    im_sq_d = im_x * im_x;
    mag_d   = MAG_W'({1'b0, re_sq_q} + {1'b0, im_sq_q});
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe_q <= '0;
      re_sq_q    <= '0;
      im_sq_q    <= '0;
      s1_sop_q   <= 1'b0;
      s1_eop_q   <= 1'b0;
      s1_idx_q   <= '0;
      s1_tag_q   <= '0;
      mag_q      <= '0;
      s2_sop_q   <= 1'b0;
      s2_eop_q   <= 1'b0;
      s2_idx_q   <= '0;
      s2_tag_q   <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], in_valid};
      if (in_valid) begin
        re_sq_q  <= re_sq_d;
        im_sq_q  <= im_sq_d;
        s1_sop_q <= in_sop;
        s1_eop_q <= in_eop;
        s1_idx_q <= in_idx;
        s1_tag_q <= in_tag;
      end
      if (vld_pipe_q[0]) begin
        mag_q    <= mag_d;
        s2_sop_q <= s1_sop_q;
        s2_eop_q <= s1_eop_q;
        s2_idx_q <= s1_idx_q;
        s2_tag_q <= s1_tag_q;
      end
    end
  end

  assign out_valid = vld_pipe_q[1];
  assign out_sop   = s2_sop_q;
  assign out_eop   = s2_eop_q;
  assign out_idx   = s2_idx_q;
  assign out_tag   = s2_tag_q;
  assign out_mag   = mag_q;

endmodule

// File: rtl/fft_peak_bin_tracker.sv
// Streaming peak-frequency detector: tracks the largest |X|^2 inside a
// programmable bin window and reports it once per well-formed frame.
//   clk_in, reset_n      : clock, async active-low reset
//   bin_if (slave)       : FFT bin stream
//   min_bin/max_bin      : inclusive search window, sampled at sop
//   threshold            : minimum |X|^2 for peak_found, sampled at sop
//   peak_valid           : 1-cycle pulse, new result (3 cycles after eop beat)
//   peak_index/mag/found : held result of the last good frame
//   frame_err            : 1-cycle pulse, malformed frame discarded
// The front end (FSM) classifies input beats; everything the back end needs
// (window hit, window-empty, min_bin, threshold) rides the pipeline tag so a
// new frame may latch its config while the previous one is still draining.
module fft_peak_bin_tracker import fft_peak_pkg::*; #(
  parameter int DATA_W  = 12,
  parameter int NFFT    = 256,
  parameter int INDEX_W = index_w(NFFT),
  parameter int MAG_W   = mag_w(DATA_W)
) (
  input  logic                   clk_in,
  input  logic                   reset_n,
  fft_peak_bin_tracker_if.slave  bin_if,
  input  logic [INDEX_W-1:0]     min_bin,
  input  logic [INDEX_W-1:0]     max_bin,
  input  logic [MAG_W-1:0]       threshold,
  output logic                   peak_valid,
  output logic [INDEX_W-1:0]     peak_index,
  output logic [MAG_W-1:0]       peak_mag,
  output logic                   peak_found,
  output logic                   frame_err
);
  localparam int                 TAG_W    = 2 + INDEX_W + MAG_W;
  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(NFFT - 1);

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] cnt_q, cnt_d, idx_next;
  logic [INDEX_W-1:0] min_q, min_d, max_q, max_d;
  logic [MAG_W-1:0]   thr_q, thr_d;
  logic               err_q, err_d;

  logic               acc, acc_sop, acc_eop;
  logic [INDEX_W-1:0] acc_idx, w_min, w_max;
  logic [MAG_W-1:0]   w_thr;
  logic               in_win, win_empty;
  logic [TAG_W-1:0]   in_tag;

  logic               s2_vld, s2_sop, s2_eop;
  logic [INDEX_W-1:0] s2_idx, s2_min;
  logic [TAG_W-1:0]   s2_tag;
  logic [MAG_W-1:0]   s2_mag, s2_thr;
  logic               s2_in_win, s2_empty;

  logic [MAG_W-1:0]   run_mag_q, run_mag_d, base_mag, new_mag;
  logic [INDEX_W-1:0] run_idx_q, run_idx_d, base_idx, new_idx;
  logic               pv_q, pv_d, pf_q, pf_d;
  logic [INDEX_W-1:0] pi_q, pi_d;
  logic [MAG_W-1:0]   pm_q, pm_d;

  assign idx_next = cnt_q + INDEX_W'(1);

  // Front end: frame FSM. Only beats of a frame still in good standing enter
  // the pipe; an erroring beat is dropped so that frame never reports.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    min_d   = min_q;
    max_d   = max_q;
    thr_d   = thr_q;
    err_d   = 1'b0;
    acc     = 1'b0;
    acc_sop = 1'b0;
    acc_eop = 1'b0;
    acc_idx = idx_next;
    w_min   = min_q;
    w_max   = max_q;
    w_thr   = thr_q;
    // The report itself is driven by the pipe; this just closes REPORT.
    if (state_q == ST_REPORT && s2_vld && s2_eop) state_d = ST_IDLE;
    if (bin_if.bin_valid) begin
      if (bin_if.bin_sop && bin_if.bin_eop) begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end else if (bin_if.bin_sop) begin
        err_d   = (state_q == ST_ACCUM);
        state_d = ST_ACCUM;
        cnt_d   = '0;
        min_d   = min_bin;
        max_d   = max_bin;
        thr_d   = threshold;
        w_min   = min_bin;
        w_max   = max_bin;
        w_thr   = threshold;
        acc     = 1'b1;
        acc_sop = 1'b1;
        acc_idx = '0;
      end else if (state_q == ST_ACCUM) begin
        cnt_d = idx_next;
        if (idx_next == LAST_IDX) begin
          if (bin_if.bin_eop) begin
            acc     = 1'b1;
            acc_eop = 1'b1;
            state_d = ST_REPORT;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (bin_if.bin_eop) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          acc = 1'b1;
        end
      end
    end
  end

  assign in_win    = (acc_idx >= w_min) && (acc_idx <= w_max);
  assign win_empty = (w_min > w_max);
  assign in_tag    = {in_win, win_empty, w_min, w_thr};

  fft_mag_sq #(
    .DATA_W (DATA_W),
    .INDEX_W(INDEX_W),
    .TAG_W  (TAG_W),
    .MAG_W  (MAG_W)
  ) u_mag (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .in_valid (acc),
    .in_sop   (acc_sop),
    .in_eop   (acc_eop),
    .in_idx   (acc_idx),
    .in_tag   (in_tag),
    .in_re    (bin_if.bin_re),
    .in_im    (bin_if.bin_im),
    .out_valid(s2_vld),
    .out_sop  (s2_sop),
    .out_eop  (s2_eop),
    .out_idx  (s2_idx),
    .out_tag  (s2_tag),
    .out_mag  (s2_mag)
  );

  assign {s2_in_win, s2_empty, s2_min, s2_thr} = s2_tag;

  // Back end: running max. The sop bin restarts from (0, min_bin); the eop
  // bin's compare is folded straight into the output registers.
  always_comb begin
    base_mag  = s2_sop ? '0 : run_mag_q;
    base_idx  = s2_sop ? s2_min : run_idx_q;
    new_mag   = base_mag;
    new_idx   = base_idx;
    // Strict > keeps the lower index on ties.
    if (s2_in_win && (s2_mag > base_mag)) begin
      new_mag = s2_mag;
      new_idx = s2_idx;
    end
    run_mag_d = run_mag_q;
    run_idx_d = run_idx_q;
    pv_d      = 1'b0;
    pi_d      = pi_q;
    pm_d      = pm_q;
    pf_d      = pf_q;
    if (s2_vld) begin
      run_mag_d = new_mag;
      run_idx_d = new_idx;
      if (s2_eop) begin
        pv_d = 1'b1;
        pi_d = new_idx;
        pm_d = new_mag;
        pf_d = !s2_empty && (new_mag >= s2_thr);
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
      thr_q     <= '0;
      err_q     <= 1'b0;
      run_mag_q <= '0;
      run_idx_q <= '0;
      pv_q      <= 1'b0;
      pi_q      <= '0;
      pm_q      <= '0;
      pf_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      min_q     <= min_d;
      max_q     <= max_d;
      thr_q     <= thr_d;
      err_q     <= err_d;
      run_mag_q <= run_mag_d;
      run_idx_q <= run_idx_d;
      pv_q      <= pv_d;
      pi_q      <= pi_d;
      pm_q      <= pm_d;
      pf_q      <= pf_d;
    end
  end

  assign peak_valid = pv_q;
  assign peak_index = pi_q;
  assign peak_mag   = pm_q;
  assign peak_found = pf_q;
  assign frame_err  = err_q;

endmodule
